cpu_bus_decoder: RTL and testbench

//  Address decoder/sequencer between the PicoRV32 native memory port and its slaves.

---
 rtl/cpu_bus_decoder_pkg.sv | 42 ++++
 rtl/bus_timeout_counter.sv | 33 +++
 rtl/cpu_bus_decoder.sv | 145 ++++++++++++++
 tb/tb_cpu_bus_decoder.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_bus_decoder_pkg.sv
// Shared definitions for the CPU bus decoder: FSM states, decode targets,
// default address windows, error word and timeout counter width.
// Build option: FISMOS_BUS_TIMEOUT_EN enables the stalled-slave watchdog.
package cpu_bus_decoder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RAM_WAIT = 3'd1,
        ST_PER_WAIT = 3'd2,
        ST_RESP     = 3'd3,
        ST_ERR      = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        TGT_RAM = 2'd0,
        TGT_PER = 2'd1,
        TGT_ERR = 2'd2
    } target_t;

    localparam logic [31:0] ERR_RDATA         = 32'hDEAD_BEEF;
    localparam logic [31:0] DEF_RAM_HIGH_ADDR = 32'h0000_3FFF;
    localparam logic [31:0] DEF_PER_BASE_ADDR = 32'h1000_0000;
    localparam logic [31:0] DEF_PER_HIGH_ADDR = 32'h1000_0FFF;
    localparam int          TIMEOUT_W         = 16;

    // RAM is checked first so that it wins if the two windows overlap.
    function automatic target_t decode_addr(
        input logic [31:0] addr,
        input logic [31:0] ram_high,
        input logic [31:0] per_base,
        input logic [31:0] per_high
    );
        if (addr <= ram_high) begin
            return TGT_RAM;
        end
        if ((addr >= per_base) && (addr <= per_high)) begin
            return TGT_PER;
        end
        return TGT_ERR;
    endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Purpose: counts wait cycles of one slave transaction and flags the cycle the limit is hit.
// Latency: expired is combinational in the limit-th consecutive enabled cycle after a clear.
// Backpressure: none; clear has priority over enable.
// Ports: clk/resetn; clear zeroes the count; enable marks a waiting cycle;
//        limit is the number of waiting cycles allowed; expired flags the last one.
module bus_timeout_counter
    import cpu_bus_decoder_pkg::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [TIMEOUT_W-1:0] limit,
    output logic                 expired
);

    logic [TIMEOUT_W-1:0] count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // count holds the waiting cycles already completed, so the current
    // cycle is the limit-th one when count has reached limit-1.
    assign expired = enable && (count == (limit - 1'b1));

endmodule

// File: rtl/cpu_bus_decoder.sv
// Purpose: routes PicoRV32 native memory requests to RAM, MMIO or a local error responder.
// Latency: valid -> ready is 2 cycles + slave wait cycles (3 with a 1-wait slave), 2 for unmapped.
// Backpressure: CPU holds valid until the single ready pulse; a silent slave stalls the CPU
//               unless FISMOS_BUS_TIMEOUT_EN is defined, which aborts after TIMEOUT_CYCLES waits.
// Ports: cpu_mem_* CPU side; ram_* and per_* slave sides (addr/wdata/wstrb wired through);
//        bus_err pulses on unmapped access or abort, bus_err_addr keeps the last erroring address.
module cpu_bus_decoder
    import cpu_bus_decoder_pkg::*;
#(
    parameter logic [31:0] RAM_HIGH_ADDR  = DEF_RAM_HIGH_ADDR,
    parameter logic [31:0] PER_BASE_ADDR  = DEF_PER_BASE_ADDR,
    parameter logic [31:0] PER_HIGH_ADDR  = DEF_PER_HIGH_ADDR,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        cpu_mem_valid,
    output logic        cpu_mem_ready,
    input  logic [31:0] cpu_mem_addr,
    input  logic [31:0] cpu_mem_wdata,
    input  logic [3:0]  cpu_mem_wstrb,
    output logic [31:0] cpu_mem_rdata,

    output logic        ram_valid,
    input  logic        ram_ready,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    output logic [3:0]  ram_wstrb,
    input  logic [31:0] ram_rdata,

    output logic        per_valid,
    input  logic        per_ready,
    output logic [31:0] per_addr,
    output logic [31:0] per_wdata,
    output logic [3:0]  per_wstrb,
    input  logic [31:0] per_rdata,

    output logic        bus_err,
    output logic [31:0] bus_err_addr
);

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
        $error("cpu_bus_decoder: TIMEOUT_CYCLES must be within 1..65535");
    end

    state_t state_q, state_d;

`ifdef FISMOS_BUS_TIMEOUT_EN
    localparam logic [TIMEOUT_W-1:0] TMO_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);

    logic tmo_expired;

    // Counter is held at zero in IDLE, so every WAIT visit starts from zero.
    bus_timeout_counter u_timeout (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (state_q == ST_IDLE),
        .enable  ((state_q == ST_RAM_WAIT) || (state_q == ST_PER_WAIT)),
        .limit   (TMO_LIMIT),
        .expired (tmo_expired)
    );
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Slave ready lines are only looked at in their own WAIT state, so a
    // stray ready in IDLE/RESP/ERR or from the other slave has no effect.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_mem_valid) begin
                    case (decode_addr(cpu_mem_addr, RAM_HIGH_ADDR, PER_BASE_ADDR, PER_HIGH_ADDR))
                        TGT_RAM: state_d = ST_RAM_WAIT;
                        TGT_PER: state_d = ST_PER_WAIT;
                        default: state_d = ST_ERR;
                    endcase
                end
            end
            ST_RAM_WAIT: begin
                if (ram_ready) begin
                    state_d = ST_RESP;
                end
`ifdef FISMOS_BUS_TIMEOUT_EN
                else if (tmo_expired) begin
                    state_d = ST_ERR;
                end
`endif
            end
            ST_PER_WAIT: begin
                if (per_ready) begin
                    state_d = ST_RESP;
                end
`ifdef FISMOS_BUS_TIMEOUT_EN
                else if (tmo_expired) begin
                    state_d = ST_ERR;
                end
`endif
            end
            ST_ERR:  state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Read data is captured on writes too; the CPU simply ignores it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cpu_mem_rdata <= '0;
            bus_err_addr  <= '0;
        end else begin
            case (state_q)
                ST_RAM_WAIT: if (ram_ready) cpu_mem_rdata <= ram_rdata;
                ST_PER_WAIT: if (per_ready) cpu_mem_rdata <= per_rdata;
                ST_ERR: begin
                    cpu_mem_rdata <= ERR_RDATA;
                    bus_err_addr  <= cpu_mem_addr;
                end
                default: ;
            endcase
        end
    end

    // Request strobes come straight from the state register, so an
    // asynchronous reset clears them immediately.
    assign ram_valid     = (state_q == ST_RAM_WAIT);
    assign per_valid     = (state_q == ST_PER_WAIT);
    assign cpu_mem_ready = (state_q == ST_RESP);
    assign bus_err       = (state_q == ST_ERR);

    assign ram_addr  = cpu_mem_addr;
    assign ram_wdata = cpu_mem_wdata;
    assign ram_wstrb = cpu_mem_wstrb;
    assign per_addr  = cpu_mem_addr;
    assign per_wdata = cpu_mem_wdata;
    assign per_wstrb = cpu_mem_wstrb;

endmodule

// File: tb/tb_cpu_bus_decoder.sv
// Testbench for cpu_bus_decoder: directed cases plus randomized requests,
// scoreboard queue filled by the driver and drained by a negedge monitor.
// Build option: FISMOS_BUS_TIMEOUT_EN selects the watchdog expectations.
module tb_cpu_bus_decoder;

    localparam logic [31:0] RAM_HI   = 32'h0000_3FFF;
    localparam logic [31:0] PER_LO   = 32'h1000_0000;
    localparam logic [31:0] PER_HI   = 32'h1000_0FFF;
    localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;
    localparam int          TB_TMO   = 8;
    localparam int          SILENT   = 1 << 30;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cpu_mem_valid, cpu_mem_ready;
    logic [31:0] cpu_mem_addr, cpu_mem_wdata, cpu_mem_rdata;
    logic [3:0]  cpu_mem_wstrb;
    logic        ram_valid, ram_ready, per_valid, per_ready;
    logic [31:0] ram_addr, ram_wdata, ram_rdata, per_addr, per_wdata, per_rdata;
    logic [3:0]  ram_wstrb, per_wstrb;
    logic        bus_err;
    logic [31:0] bus_err_addr;

    always #5 clk = ~clk;

    cpu_bus_decoder #(
        .RAM_HIGH_ADDR (RAM_HI),
        .PER_BASE_ADDR (PER_LO),
        .PER_HIGH_ADDR (PER_HI),
        .TIMEOUT_CYCLES(TB_TMO)
    ) dut (
        .clk(clk), .resetn(resetn),
        .cpu_mem_valid(cpu_mem_valid), .cpu_mem_ready(cpu_mem_ready),
        .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
        .cpu_mem_wstrb(cpu_mem_wstrb), .cpu_mem_rdata(cpu_mem_rdata),
        .ram_valid(ram_valid), .ram_ready(ram_ready), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_wstrb(ram_wstrb), .ram_rdata(ram_rdata),
        .per_valid(per_valid), .per_ready(per_ready), .per_addr(per_addr),
        .per_wdata(per_wdata), .per_wstrb(per_wstrb), .per_rdata(per_rdata),
        .bus_err(bus_err), .bus_err_addr(bus_err_addr)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
    endfunction

    function automatic logic [31:0] per_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'hC0DE_0000;
    endfunction

    // 0 = RAM, 1 = peripheral, 2 = unmapped
    function automatic int target_of(input logic [31:0] a);
        if (a <= RAM_HI) return 0;
        if (a >= PER_LO && a <= PER_HI) return 1;
        return 2;
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          tgt;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    logic [31:0] model_err_addr = '0;

    // ---------------- slave models ----------------
    int ram_delay = 0, per_delay = 0;
    int ram_cnt = 0, per_cnt = 0;
    bit noise_en = 1'b0;
    logic noise_ram = 1'b0, noise_per = 1'b0;

    always @(posedge clk) begin
        ram_cnt   <= ram_valid ? ram_cnt + 1 : 0;
        per_cnt   <= per_valid ? per_cnt + 1 : 0;
        noise_ram <= noise_en ? 1'($urandom) : 1'b0;
        noise_per <= noise_en ? 1'($urandom) : 1'b0;
    end

    // Ready after 'delay' full valid cycles; random stray readies while idle.
    assign ram_ready = ram_valid ? (ram_cnt >= ram_delay) : noise_ram;
    assign per_ready = per_valid ? (per_cnt >= per_delay) : noise_per;
    assign ram_rdata = ram_word(ram_addr);
    assign per_rdata = per_word(per_addr);

    // ---------------- monitor ----------------
    int ram_hs = 0, per_hs = 0, err_pulses = 0, ram_vc = 0, per_vc = 0;
    int last_ram_vc = 0, last_per_vc = 0;
    bit ready_prev = 1'b0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                ram_hs = 0; per_hs = 0; err_pulses = 0; ram_vc = 0; per_vc = 0;
                ready_prev = 1'b0;
            end else begin
                if (ram_valid) ram_vc++;
                if (per_valid) per_vc++;
                if (bus_err) err_pulses++;
                if (ram_valid && ram_ready && exp_q.size() > 0) begin
                    ram_hs++;
                    chk("ram_addr", ram_addr, exp_q[0].addr);
                    chk("ram_wdata", ram_wdata, exp_q[0].wdata);
                    chk("ram_wstrb", 32'(ram_wstrb), 32'(exp_q[0].wstrb));
                end
                if (per_valid && per_ready && exp_q.size() > 0) begin
                    per_hs++;
                    chk("per_addr", per_addr, exp_q[0].addr);
                    chk("per_wdata", per_wdata, exp_q[0].wdata);
                    chk("per_wstrb", 32'(per_wstrb), 32'(exp_q[0].wstrb));
                end
                if (cpu_mem_ready) begin
                    chk("ready_single_cycle", 32'(ready_prev), 32'd0);
                    chk("ready_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("rdata", cpu_mem_rdata, e.rdata);
                        chk("ram_handshakes", 32'(ram_hs), 32'(e.tgt == 0));
                        chk("per_handshakes", 32'(per_hs), 32'(e.tgt == 1));
                        chk("bus_err_pulses", 32'(err_pulses), 32'(e.tgt == 2));
                        if (e.tgt == 2) model_err_addr = e.addr;
                        chk("bus_err_addr", bus_err_addr, model_err_addr);
                    end
                    last_ram_vc = ram_vc;
                    last_per_vc = per_vc;
                    ram_hs = 0; per_hs = 0; err_pulses = 0; ram_vc = 0; per_vc = 0;
                end
                ready_prev = cpu_mem_ready;
            end
        end
    end

    // ---------------- driver ----------------
    // Issues one request, waits for its ready pulse, returns the latency in
    // clock edges, and returns after the monitor has consumed the response.
    task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                          input int rdly, input int pdly, input bit force_err, output int lat);
        exp_t e;
        bit   seen;
        e.addr  = a;
        e.wdata = wd;
        e.wstrb = ws;
        e.tgt   = force_err ? 2 : target_of(a);
        e.rdata = (e.tgt == 0) ? ram_word(a) : (e.tgt == 1) ? per_word(a) : ERR_WORD;
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        ram_delay     = rdly;
        per_delay     = pdly;
        cpu_mem_valid = 1'b1;
        cpu_mem_addr  = a;
        cpu_mem_wdata = wd;
        cpu_mem_wstrb = ws;
        lat  = 0;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (cpu_mem_ready) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            chk("response_timeout", 32'd0, 32'd1);
            exp_q.delete();
        end
        @(negedge clk);
        #1;
    endtask

    task automatic idle_bus();
        @(posedge clk);
        #1;
        cpu_mem_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cpu_mem_ready"}, 32'(cpu_mem_ready), 32'd0);
        chk({tag, "_ram_valid"}, 32'(ram_valid), 32'd0);
        chk({tag, "_per_valid"}, 32'(per_valid), 32'd0);
        chk({tag, "_bus_err"}, 32'(bus_err), 32'd0);
        chk({tag, "_cpu_mem_rdata"}, cpu_mem_rdata, 32'd0);
        chk({tag, "_bus_err_addr"}, bus_err_addr, 32'd0);
    endtask

    logic [31:0] bounds [8];
    int          lat;
    int          nrdy;
    logic [31:0] a;

    initial begin
        bounds[0] = 32'h0000_0000; bounds[1] = RAM_HI;       bounds[2] = RAM_HI + 1;
        bounds[3] = PER_LO;        bounds[4] = PER_HI;       bounds[5] = PER_HI + 1;
        bounds[6] = PER_LO - 1;    bounds[7] = 32'hFFFF_FFFF;

        resetn        = 1'b0;
        cpu_mem_valid = 1'b0;
        cpu_mem_addr  = '0;
        cpu_mem_wdata = '0;
        cpu_mem_wstrb = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        resetn = 1'b1;

        // Case 1: RAM read, one wait cycle.
        do_req(32'h0000_0010, 32'h0, 4'b0000, 1, 0, 1'b0, lat);
        chk("ram_read_latency", 32'(lat), 32'd3);

        // Case 2: peripheral write, ready on the 4th valid cycle.
        do_req(32'h1000_0004, 32'hA5A5_1234, 4'b0011, 0, 3, 1'b0, lat);
        chk("per_valid_cycles", 32'(last_per_vc), 32'd4);
        chk("per_write_ram_valid", 32'(last_ram_vc), 32'd0);

        // Case 3: just above RAM -> unmapped.
        do_req(32'h0000_4000, 32'h0, 4'b0000, 0, 0, 1'b0, lat);
        chk("unmapped_slave_valid", 32'(last_ram_vc + last_per_vc), 32'd0);
        chk("unmapped_latency", 32'(lat), 32'd2);

        // Address window boundaries, alternating read/write.
        for (int i = 0; i < 8; i++) begin
            do_req(bounds[i], $urandom, (i % 2 == 0) ? 4'b0000 : 4'b1111, 1, 1, 1'b0, lat);
        end

        // Case 6: back-to-back RAM / peripheral / RAM.
        do_req(32'h0000_0100, 32'h0, 4'b0000, 0, 0, 1'b0, lat);
        do_req(32'h1000_0200, 32'h0, 4'b0000, 0, 2, 1'b0, lat);
        do_req(32'h0000_0104, 32'h1111_2222, 4'b1000, 2, 0, 1'b0, lat);

`ifdef FISMOS_BUS_TIMEOUT_EN
        // Case 4: silent peripheral aborts after TB_TMO wait cycles.
        do_req(32'h1000_0040, 32'h0, 4'b0000, 0, SILENT, 1'b1, lat);
        chk("timeout_per_valid_cycles", 32'(last_per_vc), 32'(TB_TMO));
        // Ready in the limit cycle completes normally.
        do_req(32'h1000_0044, 32'h0, 4'b0000, 0, TB_TMO - 1, 1'b0, lat);
        chk("limit_ready_wins", 32'(last_per_vc), 32'(TB_TMO));
`endif

        // Case 5 (and non-watchdog case 4): stall a peripheral access, then reset mid-wait.
        @(posedge clk);
        #1;
        per_delay     = SILENT;
        cpu_mem_valid = 1'b1;
        cpu_mem_addr  = 32'h1000_0800;
        cpu_mem_wstrb = 4'b0000;
        nrdy = 0;
`ifdef FISMOS_BUS_TIMEOUT_EN
        repeat (TB_TMO / 2) begin
            @(posedge clk);
            #1;
            if (cpu_mem_ready) nrdy++;
        end
`else
        repeat (1000) begin
            @(posedge clk);
            #1;
            if (cpu_mem_ready) nrdy++;
        end
`endif
        chk("stall_no_ready", 32'(nrdy), 32'd0);
        chk("stall_in_per_wait", 32'(per_valid), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check_reset_outputs("midreset");
        cpu_mem_valid  = 1'b0;
        model_err_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        do_req(32'h0000_0020, 32'h0, 4'b0000, 1, 0, 1'b0, lat);
        chk("post_reset_latency", 32'(lat), 32'd3);

        // Randomized traffic with stray slave readies.
        noise_en = 1'b1;
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 5))
                0: a = {18'd0, 14'($urandom)};
                1: a = PER_LO | {20'd0, 12'($urandom)};
                2: a = bounds[$urandom_range(0, 7)];
                3: a = $urandom;
                4: a = PER_HI + 1 + 32'($urandom_range(0, 255));
                default: a = RAM_HI + 1 + 32'($urandom_range(0, 255));
            endcase
            do_req(a, $urandom, ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom),
                   $urandom_range(0, 4), $urandom_range(0, 4), 1'b0, lat);
        end
        noise_en = 1'b0;
        idle_bus();
        repeat (4) @(posedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
